seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter MAX_LEN, default 8, sets the maximum pattern length in bits; legal range is 2..32.
REQ-002 Parameter CNT_W, default 8, sets the width of the match counter.
REQ-003 Parameter LEN_W, default $clog2(MAX_LEN+1), sets the width of the pattern-length field.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port cfg_load, input, 1 bit: strobe that latches cfg_pat, cfg_len and cfg_overlap.
REQ-007 Port cfg_pat, input, MAX_LEN bits: target pattern; bit [cfg_len-1] is the first bit received and bit [0] is the last.
REQ-008 Port cfg_len, input, LEN_W bits: pattern length.
REQ-009 Port cfg_overlap, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping.
REQ-010 Port en, input, 1 bit: serial-bit valid; in_seq is sampled only when en=1.
REQ-011 Port in_seq, input, 1 bit: serial data bit.
REQ-012 Port seq_detected, output, 1 bit: registered one-cycle match pulse.
REQ-013 Port match_count, output, CNT_W bits: saturating count of matches.
REQ-014 Port armed, output, 1 bit: set while a valid configuration is loaded.
REQ-015 Port cfg_err, output, 1 bit: sticky flag for a rejected configuration.

Function
REQ-016 The block SHALL implement a three-state machine (IDLE, HUNT, HIT), with every output a function of registered state only (Moore).
- IDLE: unconfigured.
- HUNT: searching.
- HIT: a match was completed on the previous sampling edge.
REQ-017 The block SHALL hold a history shift register hist[MAX_LEN-1:0] and a fill counter fill (0..MAX_LEN).
- On each rising edge with en=1 in HUNT or HIT, the new bit shifts in at hist[0].
- fill increments and saturates at MAX_LEN.
REQ-018 A match SHALL occur on an en=1 edge when both of the following hold for the post-shift values:
- the low cur_len bits of hist equal the low cur_len bits of cur_pat;
- fill >= cur_len.
REQ-019 On a match, the state SHALL go to HIT; otherwise it goes to (or stays in) HUNT.
REQ-020 If en=0 in HIT, the state SHALL return to HUNT, and hist and fill are held.
REQ-021 seq_detected SHALL be 1 exactly when the state is HIT.
- The pulse is one cycle long and appears in the cycle after the edge that sampled the completing bit.
- Back-to-back matches on consecutive en=1 edges keep seq_detected high for consecutive cycles.
REQ-022 Overlap mode (cur_overlap=1) SHALL leave hist and fill unchanged by a match.
REQ-023 Non-overlap mode (cur_overlap=0) SHALL clear fill to 0 on the matching edge, so no bit participates in two matches.
REQ-024 match_count SHALL increment by 1 on every match and saturate at 2^CNT_W-1 (no wrap).
REQ-025 cfg_load=1 with 2 <= cfg_len <= MAX_LEN SHALL, on that edge:
- latch cfg_pat, cfg_len and cfg_overlap into cur_pat, cur_len and cur_overlap;
- clear hist, fill and match_count;
- enter HUNT, set armed=1 and clear cfg_err.
The bit on in_seq at that edge is discarded.
REQ-026 cfg_load=1 with cfg_len < 2 or cfg_len > MAX_LEN SHALL:
- set cfg_err=1;
- enter IDLE with armed=0;
- clear hist, fill and match_count.
REQ-027 cfg_load SHALL take priority over a simultaneous en=1, and no match is evaluated on that edge.
REQ-028 In IDLE, en and in_seq SHALL be ignored and seq_detected stays 0.

Reset
REQ-029 rst=1 at a rising edge SHALL override all other inputs.
REQ-030 Reset SHALL set:
- state to IDLE;
- hist, fill, cur_pat, cur_len, cur_overlap and match_count to 0;
- seq_detected=0, armed=0, cfg_err=0.
REQ-031 Reset asserted mid-pattern or during HIT SHALL abort the operation without emitting a pulse.
- After reset, the block stays in IDLE until a valid cfg_load.

Verification
REQ-032 Load pat=5'b11101, len=5, overlap=1, then send 1,1,1,0,1 with en=1 every cycle -> seq_detected pulses once, in the cycle after the 5th bit; match_count=1.
REQ-033 Load pat=3'b101, len=3, overlap=1, then send 1,0,1,0,1 -> seq_detected pulses after bit 3 and after bit 5; match_count=2.
REQ-034 Same as REQ-033 with overlap=0 -> one pulse, after bit 3; match_count=1.
REQ-035 Load len=1, and separately load len=MAX_LEN+1 -> cfg_err=1, armed=0, and seq_detected never asserts.
REQ-036 Load pat=2'b11, len=2, overlap=1 with CNT_W=2, then send seven 1s -> seq_detected stays high for 6 consecutive cycles; match_count saturates at 3.
REQ-037 Send 1,1,1,0 of pattern 11101, assert rst for one cycle, then send 1 -> no pulse; state is IDLE.
REQ-038 Send 1,1,1,0 of pattern 11101 with en=0 gaps between bits, then 1 -> exactly one pulse.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-configurable serial pattern detector.
// A pattern of 2..MAX_LEN bits is loaded with cfg_load. The most recent
// received bits are then compared against it on every valid input bit,
// in either overlapping or non-overlapping mode.
// Every output is registered and depends only on stored state.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               en,
    input  logic               in_seq,
    output logic               seq_detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [MAX_LEN-1:0] hist_reg;
    logic [LEN_W-1:0]   fill_reg;
    logic [MAX_LEN-1:0] cur_pat_reg;
    logic [LEN_W-1:0]   cur_len_reg;
    logic               cur_overlap_reg;

    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] len_mask;
    logic               cfg_valid;
    logic               match_next;

    // The new bit enters at the LSB, so the newest pattern bit lines up with cur_pat[0].
    assign hist_next = {hist_reg[MAX_LEN-2:0], in_seq};

    // Fill saturates at MAX_LEN. The history cannot hold more bits than that.
    assign fill_next = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + 1'b1;

    // Only the low cur_len bits take part in the comparison.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (cur_len_reg > LEN_W'(gi));
        end
    endgenerate

    assign cfg_valid  = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
    assign match_next = (((hist_next ^ cur_pat_reg) & len_mask) == '0)
                        && (fill_next >= cur_len_reg);

    // Single FSM covering configuration, history tracking, match counting and the registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            hist_reg        <= '0;
            fill_reg        <= '0;
            cur_pat_reg     <= '0;
            cur_len_reg     <= '0;
            cur_overlap_reg <= 1'b0;
            match_count     <= '0;
            seq_detected    <= 1'b0;
            armed           <= 1'b0;
            cfg_err         <= 1'b0;
        end else if (cfg_load) begin
            // A configuration load wins over a bit arriving on the same edge; that bit is dropped.
            hist_reg     <= '0;
            fill_reg     <= '0;
            match_count  <= '0;
            seq_detected <= 1'b0;
            if (cfg_valid) begin
                cur_pat_reg     <= cfg_pat;
                cur_len_reg     <= cfg_len;
                cur_overlap_reg <= cfg_overlap;
                state_reg       <= HUNT;
                armed           <= 1'b1;
                cfg_err         <= 1'b0;
            end else begin
                state_reg <= IDLE;
                armed     <= 1'b0;
                cfg_err   <= 1'b1;
            end
        end else begin
            case (state_reg)
                HUNT, HIT: begin
                    if (en) begin
                        hist_reg <= hist_next;
                        if (match_next) begin
                            state_reg    <= HIT;
                            seq_detected <= 1'b1;
                            if (match_count != '1) begin
                                match_count <= match_count + 1'b1;
                            end
                            // In non-overlap mode the matched bits are retired and cannot count again.
                            fill_reg <= cur_overlap_reg ? fill_next : '0;
                        end else begin
                            state_reg    <= HUNT;
                            seq_detected <= 1'b0;
                            fill_reg     <= fill_next;
                        end
                    end else begin
                        state_reg    <= HUNT;
                        seq_detected <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    seq_detected <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed testbench for seq_detect_param. A default instance and a CNT_W=2
// instance share the same stimulus.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       en;
    logic       in_seq;

    logic       seq_detected;
    logic [7:0] match_count;
    logic       armed;
    logic       cfg_err;

    logic       s_seq_detected;
    logic [1:0] s_match_count;
    logic       s_armed;
    logic       s_cfg_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .in_seq(in_seq),
        .seq_detected(seq_detected), .match_count(match_count),
        .armed(armed), .cfg_err(cfg_err)
    );

    seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .in_seq(in_seq),
        .seq_detected(s_seq_detected), .match_count(s_match_count),
        .armed(s_armed), .cfg_err(s_cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        cfg_load = 1'b1; cfg_pat = pat; cfg_len = len; cfg_overlap = ov;
        en = 1'b1; in_seq = 1'b1;          // this bit must be discarded
        tick();
        cfg_load = 1'b0; en = 1'b0;
        $display("load pat=%b len=%0d ov=%0d -> armed=%0d cfg_err=%0d", pat, len, ov, armed, cfg_err);
    endtask

    task automatic send(input logic b, input logic exp_seq, input string tag);
        en = 1'b1; in_seq = b;
        tick();
        $display("bit %0d -> seq_detected=%0d match_count=%0d", b, seq_detected, match_count);
        chk(tag, {31'd0, seq_detected}, {31'd0, exp_seq});
    endtask

    task automatic idle(input string tag);
        en = 1'b0;
        tick();
        chk(tag, {31'd0, seq_detected}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_pat = '0; cfg_len = '0;
        cfg_overlap = 1'b0; en = 1'b0; in_seq = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_seq", {31'd0, seq_detected}, 32'd0);
        chk("rst_cnt", {24'd0, match_count}, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        // Idle ignores input bits.
        send(1'b1, 1'b0, "idle_ignore");
        chk("idle_armed", {31'd0, armed}, 32'd0);

        // Pattern 11101, overlap: single pulse after bit 5.
        load(8'b11101, 4'd5, 1'b1);
        chk("ld_armed", {31'd0, armed}, 32'd1);
        chk("ld_err", {31'd0, cfg_err}, 32'd0);
        chk("ld_seq", {31'd0, seq_detected}, 32'd0);
        send(1, 0, "p5_b1"); send(1, 0, "p5_b2"); send(1, 0, "p5_b3");
        send(0, 0, "p5_b4"); send(1, 1, "p5_b5");
        chk("p5_cnt", {24'd0, match_count}, 32'd1);
        idle("p5_after");
        chk("p5_cnt_hold", {24'd0, match_count}, 32'd1);

        // 101 overlapping: pulses after bits 3 and 5.
        load(8'b101, 4'd3, 1'b1);
        chk("ov_cnt_clr", {24'd0, match_count}, 32'd0);
        send(1, 0, "ov_b1"); send(0, 0, "ov_b2"); send(1, 1, "ov_b3");
        send(0, 0, "ov_b4"); send(1, 1, "ov_b5");
        chk("ov_cnt", {24'd0, match_count}, 32'd2);
        idle("ov_after");

        // 101 non-overlapping: only the first match.
        load(8'b101, 4'd3, 1'b0);
        send(1, 0, "nov_b1"); send(0, 0, "nov_b2"); send(1, 1, "nov_b3");
        send(0, 0, "nov_b4"); send(1, 0, "nov_b5");
        chk("nov_cnt", {24'd0, match_count}, 32'd1);
        idle("nov_after");

        // Rejected lengths: 1 and MAX_LEN+1.
        load(8'b1, 4'd1, 1'b1);
        chk("len1_err", {31'd0, cfg_err}, 32'd1);
        chk("len1_armed", {31'd0, armed}, 32'd0);
        chk("len1_cnt", {24'd0, match_count}, 32'd0);
        send(1, 0, "len1_b1"); send(1, 0, "len1_b2");
        load(8'b11, 4'd2, 1'b1);
        chk("err_clr", {31'd0, cfg_err}, 32'd0);
        load(8'hFF, 4'd9, 1'b1);
        chk("len9_err", {31'd0, cfg_err}, 32'd1);
        chk("len9_armed", {31'd0, armed}, 32'd0);
        for (int i = 0; i < 10; i++) send(1, 0, "len9_bit");

        // Full-width pattern, length MAX_LEN, non-overlapping.
        load(8'b10110011, 4'd8, 1'b0);
        send(1, 0, "l8_b1"); send(0, 0, "l8_b2"); send(1, 0, "l8_b3"); send(1, 0, "l8_b4");
        send(0, 0, "l8_b5"); send(0, 0, "l8_b6"); send(1, 0, "l8_b7"); send(1, 1, "l8_b8");
        chk("l8_cnt", {24'd0, match_count}, 32'd1);
        idle("l8_after");

        // 11 overlapping, seven 1s: six back-to-back pulses; CNT_W=2 saturates at 3.
        load(8'b11, 4'd2, 1'b1);
        send(1, 0, "sat_b1");
        for (int i = 2; i <= 7; i++) begin
            send(1, 1, "sat_pulse");
            chk("sat_c8", {24'd0, match_count}, i - 1);
            chk("sat_c2", {30'd0, s_match_count}, (i - 1 > 3) ? 3 : i - 1);
            chk("sat_s_seq", {31'd0, s_seq_detected}, 32'd1);
        end
        idle("sat_after");
        chk("sat_c2_hold", {30'd0, s_match_count}, 32'd3);

        // Reset mid-pattern aborts without a pulse and leaves the block unconfigured.
        load(8'b11101, 4'd5, 1'b1);
        send(1, 0, "ra_b1"); send(1, 0, "ra_b2"); send(1, 0, "ra_b3"); send(0, 0, "ra_b4");
        rst = 1'b1; en = 1'b1; in_seq = 1'b1;
        tick();
        rst = 1'b0;
        chk("ra_seq", {31'd0, seq_detected}, 32'd0);
        chk("ra_armed", {31'd0, armed}, 32'd0);
        chk("ra_cnt", {24'd0, match_count}, 32'd0);
        send(1, 0, "ra_b5");
        chk("ra_idle", {31'd0, armed}, 32'd0);

        // Reset while in HIT suppresses the following pulse.
        load(8'b11, 4'd2, 1'b1);
        send(1, 0, "rh_b1"); send(1, 1, "rh_b2");
        rst = 1'b1; en = 1'b1; in_seq = 1'b1;
        tick();
        rst = 1'b0;
        chk("rh_seq", {31'd0, seq_detected}, 32'd0);
        send(1, 0, "rh_b3");

        // Gapped bits: en=0 cycles hold the history.
        load(8'b11101, 4'd5, 1'b1);
        send(1, 0, "gap_b1"); idle("gap_i1");
        send(1, 0, "gap_b2"); idle("gap_i2");
        send(1, 0, "gap_b3"); idle("gap_i3");
        send(0, 0, "gap_b4"); idle("gap_i4");
        send(1, 1, "gap_b5");
        chk("gap_cnt", {24'd0, match_count}, 32'd1);
        idle("gap_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
